// File: rtl/spi_pkg.sv
// Shared SPI link types and constants for the MCU-to-FPGA transmitter path.
package spi_pkg;

    localparam int SPI_WORD_W = 16;

    typedef logic [SPI_WORD_W-1:0] spi_word_t;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } spi_tx_state_e;

    localparam spi_word_t SPI_FILL_DEFAULT = '0;

endpackage

// File: rtl/spi_tx_hold.sv
// One-entry holding register between core logic (valid/ready) and the SPI shifter.
module spi_tx_hold
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             consume,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full
);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;

    // A write is accepted in the same cycle the shifter consumes the held word.
    always_comb begin
        wr_ready = !full_q || consume;
        hold_d   = hold_q;
        full_d   = full_q;
        if (consume) begin
            full_d = 1'b0;
        end
        if (wr_valid && wr_ready) begin
            hold_d = wr_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    assign hold_data = hold_q;
    assign hold_full = full_q;

endmodule

// File: rtl/spi_tx_shifter.sv
// SPI slave transmitter: shifts WIDTH-bit words MSB-first onto shiftout while enable is high.
// Optional SPI_TX_UNDERRUN_CNT_EN adds a saturating 8-bit underrun_count output.
module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int               WIDTH     = SPI_WORD_W,
    parameter logic [WIDTH-1:0] FILL_WORD = WIDTH'(SPI_FILL_DEFAULT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             shiftout,
    output logic             busy,
    output logic             word_done,
    output logic             underrun,
    output logic             aborted
`ifdef SPI_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0]       underrun_count
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             word_done_q, word_done_d;
    logic             underrun_q, underrun_d;
    logic             aborted_q, aborted_d;

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             consume;
    logic [WIDTH-1:0] next_word;
    spi_tx_state_e    state;

    spi_tx_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .wr_data   (tx_data),
        .wr_valid  (tx_valid),
        .wr_ready  (tx_ready),
        .consume   (consume),
        .hold_data (hold_data),
        .hold_full (hold_full)
    );

    // Bit 0 of a new word comes straight from the hold register so frames start with no latency.
    always_comb begin
        state       = (cnt_q == '0) ? TX_IDLE : TX_SHIFT;
        next_word   = hold_full ? hold_data : FILL_WORD;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        underrun_d  = 1'b0;
        aborted_d   = 1'b0;
        consume     = 1'b0;
        shiftout    = 1'b0;

        case (state)
            TX_IDLE: begin
                if (enable) begin
                    shiftout   = next_word[WIDTH-1];
                    shreg_d    = next_word << 1;
                    cnt_d      = CNT_W'(1);
                    consume    = 1'b1;
                    underrun_d = !hold_full;
                end
            end
            TX_SHIFT: begin
                if (enable) begin
                    shiftout = shreg_q[WIDTH-1];
                    shreg_d  = shreg_q << 1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d       = '0;
                        word_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
            underrun_q  <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
            underrun_q  <= underrun_d;
            aborted_q   <= aborted_d;
        end
    end

    assign busy      = (state == TX_SHIFT);
    assign word_done = word_done_q;
    assign underrun  = underrun_q;
    assign aborted   = aborted_q;

`ifdef SPI_TX_UNDERRUN_CNT_EN
    logic [7:0] urun_cnt_q, urun_cnt_d;

    always_comb begin
        urun_cnt_d = urun_cnt_q;
        if (underrun_d && (urun_cnt_q != 8'hFF)) begin
            urun_cnt_d = urun_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            urun_cnt_q <= '0;
        end else begin
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign underrun_count = urun_cnt_q;
`endif

endmodule

// File: tb/tb_spi_tx_shifter.sv
// Directed self-checking bench for spi_tx_shifter; the bench models the SPI receiver itself.
// Define SPI_TX_UNDERRUN_CNT_EN to also check underrun_count.
module tb_spi_tx_shifter;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        shiftout;
    logic        busy;
    logic        word_done;
    logic        underrun;
    logic        aborted;
`ifdef SPI_TX_UNDERRUN_CNT_EN
    logic [7:0]  underrun_count;
`endif

    int checkCount = 0;
    int errorCount = 0;

    logic        pendValid;
    logic [15:0] pendData;
    logic        bitQ[$];
    int          doneCnt, underCnt, abortCnt, busyCnt, readyLowCnt, acceptCnt, idleBitErr;
    int          cycleIdx, firstUnder, firstAbort;

    spi_tx_shifter dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .shiftout  (shiftout),
        .busy      (busy),
        .word_done (word_done),
        .underrun  (underrun),
        .aborted   (aborted)
`ifdef SPI_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearStats();
        bitQ.delete();
        doneCnt     = 0;
        underCnt    = 0;
        abortCnt    = 0;
        busyCnt     = 0;
        readyLowCnt = 0;
        acceptCnt   = 0;
        idleBitErr  = 0;
        cycleIdx    = 0;
        firstUnder  = -1;
        firstAbort  = -1;
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        enable    = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        pendValid = 1'b0;
        pendData  = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        clearStats();
    endtask

    // Runs n cycles with the given enable, acting as both the core-side writer and the SPI receiver.
    task automatic applyStimulus(input int n, input logic en);
        logic acceptNow;
        for (int i = 0; i < n; i++) begin
            enable   = en;
            tx_valid = pendValid;
            tx_data  = pendData;
            #1;
            acceptNow = pendValid && tx_ready;
            if (en) bitQ.push_back(shiftout);
            else if (shiftout !== 1'b0) idleBitErr++;
            if (busy) busyCnt++;
            if (!tx_ready) readyLowCnt++;
            @(posedge clock);
            #1;
            if (acceptNow) begin
                pendValid = 1'b0;
                acceptCnt++;
            end
            doneCnt  += int'(word_done);
            underCnt += int'(underrun);
            abortCnt += int'(aborted);
            if (underrun && firstUnder < 0) firstUnder = cycleIdx;
            if (aborted && firstAbort < 0) firstAbort = cycleIdx;
            cycleIdx++;
        end
        tx_valid = 1'b0;
    endtask

    function automatic logic [15:0] wordAt(input int start);
        logic [15:0] w = '0;
        for (int k = 0; k < 16; k++) w = {w[14:0], bitQ[start + k]};
        return w;
    endfunction

    task automatic queueWrite(input logic [15:0] data);
        pendValid = 1'b1;
        pendData  = data;
    endtask

    initial begin
        logic [15:0] expWord;

        // Reset values while reset is held
        reset = 1'b1; enable = 1'b0; tx_valid = 1'b0; tx_data = '0;
        #3;
        checkOutput("rst_tx_ready", tx_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_shiftout", shiftout, 0);
        checkOutput("rst_pulses", {word_done, underrun, aborted}, 0);
        applyReset();

        $display("[TB] single word");
        queueWrite(16'h8DF3);
        applyStimulus(1, 1'b0);
        checkOutput("sw_accept", acceptCnt, 1);
        clearStats();
        applyStimulus(16, 1'b1);
        applyStimulus(2, 1'b0);
        expWord = 16'h8DF3;
        for (int i = 0; i < 16; i++) checkOutput($sformatf("sw_bit%0d", i), bitQ[i], expWord[15 - i]);
        checkOutput("sw_rx", wordAt(0), 16'h8DF3);
        checkOutput("sw_done", doneCnt, 1);
        checkOutput("sw_underrun", underCnt, 0);
        checkOutput("sw_busy_cycles", busyCnt, 15);

        $display("[TB] back-to-back");
        applyReset();
        queueWrite(16'h8DF3);
        applyStimulus(1, 1'b0);
        clearStats();
        queueWrite(16'h1234);
        applyStimulus(32, 1'b1);
        checkOutput("b2b_rx0", wordAt(0), 16'h8DF3);
        checkOutput("b2b_rx1", wordAt(16), 16'h1234);
        checkOutput("b2b_done", doneCnt, 2);
        checkOutput("b2b_underrun", underCnt, 0);
        checkOutput("b2b_ready_low", readyLowCnt, 15);
        checkOutput("b2b_busy_cycles", busyCnt, 30);

        $display("[TB] underrun");
        applyReset();
        applyStimulus(16, 1'b1);
        checkOutput("ur_rx", wordAt(0), 16'h0000);
        checkOutput("ur_count", underCnt, 1);
        checkOutput("ur_first_cycle", firstUnder, 0);
        checkOutput("ur_done", doneCnt, 1);
`ifdef SPI_TX_UNDERRUN_CNT_EN
        checkOutput("ur_counter", underrun_count, 1);
`endif

        $display("[TB] abort");
        applyReset();
        queueWrite(16'hA5A5);
        applyStimulus(1, 1'b0);
        queueWrite(16'h0F0F);
        clearStats();
        applyStimulus(5, 1'b1);
        applyStimulus(1, 1'b0);
        checkOutput("ab_busy_after", busy, 0);
        applyStimulus(2, 1'b0);
        checkOutput("ab_busy_gap", busy, 0);
        checkOutput("ab_count", abortCnt, 1);
        checkOutput("ab_first_cycle", firstAbort, 5);
        checkOutput("ab_gap_shiftout", idleBitErr, 0);
        clearStats();
        applyStimulus(16, 1'b1);
        checkOutput("ab_rx", wordAt(0), 16'h0F0F);
        checkOutput("ab_done", doneCnt, 1);
        checkOutput("ab_underrun", underCnt, 0);

        $display("[TB] backpressure");
        applyReset();
        queueWrite(16'h1111);
        applyStimulus(1, 1'b0);
        queueWrite(16'h2222);
        applyStimulus(3, 1'b0);
        checkOutput("bp_accepts", acceptCnt, 1);
        checkOutput("bp_ready_low", readyLowCnt, 3);
        clearStats();
        applyStimulus(16, 1'b1);
        checkOutput("bp_accept_at_start", acceptCnt, 1);
        applyStimulus(16, 1'b1);
        checkOutput("bp_rx0", wordAt(0), 16'h1111);
        checkOutput("bp_rx1", wordAt(16), 16'h2222);
        checkOutput("bp_underrun", underCnt, 0);

        $display("[TB] reset mid-word");
        applyReset();
        queueWrite(16'hFF00);
        applyStimulus(1, 1'b0);
        queueWrite(16'hC0DE);
        applyStimulus(7, 1'b1);
        enable = 1'b1;
        #1;
        checkOutput("rm_pre_shiftout", shiftout, 1);
        checkOutput("rm_pre_busy", busy, 1);
        checkOutput("rm_pre_ready", tx_ready, 0);
        #1 reset = 1'b1;
        #1;
        checkOutput("rm_shiftout", shiftout, 0);
        checkOutput("rm_busy", busy, 0);
        checkOutput("rm_ready", tx_ready, 1);
        @(posedge clock);
        #1 reset = 1'b0;
        enable = 1'b0;
        clearStats();
        applyStimulus(16, 1'b1);
        checkOutput("rm_next_underrun", underCnt, 1);
        checkOutput("rm_next_rx", wordAt(0), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/spi_tx_shifter.md
Name: spi_tx_shifter

Overview:
- SPI slave-side transmitter; the opposite direction of the existing SPI shift-in receiver.
- Serialises 16-bit words MSB-first onto `shiftout`, one bit per `clock`, while `enable` (= !ncs) is high.
- Same bit timing as the receiver, so each `shiftout` bit is valid in the cycle the receiver samples it.
- Fed by core logic through a one-entry holding register with a valid/ready handshake; sits beside the receiver in the MCU-to-FPGA link.

Parameters:
- WIDTH, 16, bits per SPI word.
- FILL_WORD, 16'h0000, word shifted out when no data is held at frame start (underrun).

Ports:
- clock  in  1  system clock; also the bit clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  frame active (chip select asserted); already synchronous to clock.
- tx_data  in  WIDTH  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register can accept; transfer occurs when tx_valid && tx_ready at a rising edge.
- shiftout  out  1  serial data (MISO).
- busy  out  1  word in progress (bit counter != 0).
- word_done  out  1  one-cycle pulse after the last bit of a word shifted.
- underrun  out  1  one-cycle pulse when FILL_WORD is used.
- aborted  out  1  one-cycle pulse when enable drops mid-word.

Behaviour:
- Reset is asynchronous and active-high. While in reset:
  - Registers: hold_full=0, shreg=0, cnt=0.
  - Outputs: word_done, underrun and aborted all 0; tx_ready=1; busy=0; shiftout=0.
- Reset mid-frame discards the held word and the partial word.
- next_word = hold_full ? hold : FILL_WORD.
- shiftout is combinational from registers, no added latency:
  - enable=1 && cnt==0: next_word[WIDTH-1].
  - enable=1 && cnt!=0: shreg[WIDTH-1].
  - enable=0: 0.
- Bit counter cnt runs 0..WIDTH-1.
  - State IDLE: cnt==0. State SHIFT: cnt!=0.
  - busy is 1 exactly when the block is in SHIFT.
- IDLE, enable=1:
  - shreg <= next_word<<1; cnt <= 1; hold_full <= 0.
  - If hold_full was 0, underrun pulses in the next cycle.
- SHIFT, enable=1:
  - shreg <= shreg<<1.
  - If cnt==WIDTH-1: cnt <= 0 and word_done pulses in the next cycle. Otherwise cnt <= cnt+1.
- Back-to-back words: with enable held, word N+1 bit 0 follows word N bit WIDTH-1 with no gap cycle.
- SHIFT, enable=0 (abort):
  - cnt <= 0; the partial word is lost; aborted pulses in the next cycle.
  - hold is untouched.
- IDLE, enable=0: no state change.
- tx_ready = !hold_full || (enable && cnt==0), i.e. a load is allowed in the same cycle the held word is consumed.
- Accept writes hold <= tx_data and hold_full <= 1. A same-cycle consume and accept leaves hold_full=1 with the new word.
- No bypass: tx_valid arriving in the consume cycle while hold_full=0 still produces an underrun. The accepted word goes out in the next frame.
- Outputs word_done, underrun and aborted are registered and mutually exclusive per cycle, except that underrun and aborted cannot coincide.

Optional Feature:
- Macro: SPI_TX_UNDERRUN_CNT_EN.
- Defined: adds output `underrun_count` [7:0].
  - Saturating count of underrun events; saturates at 8'hFF.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package spi_pkg holds:
  - SPI_WORD_W = 16.
  - typedef spi_word_t = logic [SPI_WORD_W-1:0].
  - typedef enum spi_tx_state_e {TX_IDLE, TX_SHIFT}, used for debug/assertion visibility.
  - constant SPI_FILL_DEFAULT.
- One sub-module: spi_tx_hold, the one-entry valid/ready holding register with the consume input. The shifter, counter and pulses stay in spi_tx_shifter.

Test Plan:
- Single word loopback:
  - Stimulus: load 16'h8DF3 while idle, then enable for 16 cycles; shiftout drives the existing receiver.
  - Required: bits 1,0,0,0,1,1,0,1,1,1,1,1,0,0,1,1; receiver q=16'h8DF3; word_done pulses once; underrun=0.
- Back-to-back:
  - Stimulus: load 16'h8DF3, then load 16'h1234 during word 1; hold enable for 32 cycles.
  - Required: q=16'h8DF3 then 16'h1234; no gap cycle; two word_done pulses; tx_ready=0 from the second load until cycle 16.
- Underrun:
  - Stimulus: enable for 16 cycles with no load.
  - Required: shiftout=0 for all 16 bits; underrun pulses once in cycle 1; underrun_count=1 when SPI_TX_UNDERRUN_CNT_EN is defined.
- Abort:
  - Stimulus: load 16'hA5A5 and 16'h0F0F, enable 5 cycles, drop enable 3 cycles, re-enable 16 cycles.
  - Required: aborted pulses once; second frame sends 16'h0F0F; busy=0 during the gap.
- Backpressure:
  - Stimulus: two writes while idle with enable=0.
  - Required: first is accepted; second sees tx_ready=0 and is held off until frame start.
- Reset mid-word:
  - Stimulus: assert reset asynchronously at bit 7.
  - Required: shiftout, busy and tx_ready take reset values immediately; the next frame underruns.
